// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache flush engine.
package dcache_pkg;

   localparam int S_INDEX  = 3;
   localparam int NUM_WAYS = 2;
   localparam int S_TAG    = 24;
   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 256;

   // Walker states; explicit codes keep the debug encoding stable across tools.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      CHECK = 3'd2,
      WB    = 3'd3,
      CLEAR = 3'd4,
      DONE  = 3'd5
   } flush_state_t;

   // Physical address of the first byte of a line.
   function automatic logic [31:0] line_addr(input logic [S_TAG-1:0]   tag,
                                             input logic [S_INDEX-1:0] set);
      return {tag, set, {S_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_flush_way_sel.sv
// Lowest-index priority encoder over valid & dirty: picks the next line to write back.
module dcache_flush_way_sel #(
   parameter int num_ways = 2,
   parameter int s_way    = 1
) (
   input  logic [num_ways-1:0] valid_in,
   input  logic [num_ways-1:0] dirty_in,
   output logic                found,
   output logic [s_way-1:0]    way
);

   // Scan from the top way down so the lowest matching way is the last assignment.
   always_comb begin
      found = 1'b0;
      way   = '0;
      for (int w = num_ways - 1; w >= 0; w--) begin
         if (valid_in[w] && dirty_in[w]) begin
            found = 1'b1;
            way   = s_way'(w);
         end
      end
   end

endmodule

// File: rtl/dcache_flush_walker.sv
// Flush engine: walks every set/way via the arrays' registered read port, writes back
// each valid+dirty line, clears its dirty bit, then re-reads the set before moving on.
// Handshake: pmem_write is held with stable address/data until pmem_resp is seen high
// on a rising edge while in WB; pmem_resp at any other time has no effect.
module dcache_flush_walker
   import dcache_pkg::*;
#(
   parameter int s_index  = S_INDEX,
   parameter int num_ways = NUM_WAYS,
   parameter int s_tag    = S_TAG,
   parameter int s_offset = S_OFFSET,
   parameter int s_line   = S_LINE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_req,
   output logic                       flush_busy,
   output logic                       flush_done,
   output logic [s_index-1:0]         arr_rindex,
   output logic [s_index-1:0]         arr_windex,
   input  logic [num_ways-1:0]        valid_in,
   input  logic [num_ways-1:0]        dirty_in,
   input  logic [num_ways*s_tag-1:0]  tag_in,
   input  logic [num_ways*s_line-1:0] data_in,
   output logic [num_ways-1:0]        dirty_load,
   output logic                       dirty_datain,
   output logic                       pmem_write,
   output logic [31:0]                pmem_address,
   output logic [s_line-1:0]          pmem_wdata,
   input  logic                       pmem_resp,
   output flush_state_t               flush_state
);

   localparam int s_way = (num_ways > 1) ? $clog2(num_ways) : 1;
   localparam logic [s_index-1:0] last_set = {s_index{1'b1}};

   flush_state_t        state;
   logic [s_index-1:0]  set_q;
   logic [s_way-1:0]    way_q;
   logic [31:0]         addr_q;
   logic [s_line-1:0]   data_q;

   logic                sel_found;
   logic [s_way-1:0]    sel_way;
   logic [s_tag-1:0]    sel_tag;
   logic [s_line-1:0]   sel_data;

   dcache_flush_way_sel #(
      .num_ways (num_ways),
      .s_way    (s_way)
   ) u_way_sel (
      .valid_in (valid_in),
      .dirty_in (dirty_in),
      .found    (sel_found),
      .way      (sel_way)
   );

   // Mux the chosen way's tag and line out of the flattened array buses.
   always_comb begin
      sel_tag  = '0;
      sel_data = '0;
      for (int w = 0; w < num_ways; w++) begin
         if (s_way'(w) == sel_way) begin
            sel_tag  = tag_in[w*s_tag +: s_tag];
            sel_data = data_in[w*s_line +: s_line];
         end
      end
   end

   // Walk FSM with the set counter and the latched write-back line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         set_q  <= '0;
         way_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_req) begin
                  set_q <= '0;
                  state <= READ;
               end
            end
            READ: state <= CHECK;
            CHECK: begin
               if (sel_found) begin
                  way_q  <= sel_way;
                  addr_q <= line_addr(sel_tag, set_q);
                  data_q <= sel_data;
                  state  <= WB;
               end else if (set_q == last_set) begin
                  state <= DONE;
               end else begin
                  set_q <= set_q + 1'b1;
                  state <= READ;
               end
            end
            WB: begin
               if (pmem_resp) state <= CLEAR;
            end
            // Re-read the same set: the array output right after a load is not trusted.
            CLEAR: state <= READ;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Dirty-bit clear strobe for the way just written back.
   always_comb begin
      dirty_load = '0;
      if (state == CLEAR) dirty_load[way_q] = 1'b1;
   end

   assign flush_busy   = (state != IDLE);
   assign flush_done   = (state == DONE);
   assign arr_rindex   = (state == IDLE) ? '0 : set_q;
   assign arr_windex   = (state == CLEAR) ? set_q : '0;
   assign dirty_datain = 1'b0;
   assign pmem_write   = (state == WB);
   assign pmem_address = addr_q;
   assign pmem_wdata   = data_q;
   assign flush_state  = state;

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Bench for dcache_flush_walker: behavioural array and memory models around the DUT,
// directed scenarios followed by randomized array contents.
module tb_dcache_flush_walker;

   localparam int NS = 8;
   localparam int NW = 2;
   localparam int ST = 24;
   localparam int SL = 256;
   localparam int W  = 1 + 32 + SL;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush_req = 1'b0;
   logic             flush_busy, flush_done;
   logic [2:0]       arr_rindex, arr_windex;
   logic [NW-1:0]    valid_in = '0, dirty_in = '0;
   logic [NW*ST-1:0] tag_in = '0;
   logic [NW*SL-1:0] data_in = '0;
   logic [NW-1:0]    dirty_load;
   logic             dirty_datain;
   logic             pmem_write;
   logic [31:0]      pmem_address;
   logic [SL-1:0]    pmem_wdata;
   logic             pmem_resp = 1'b0;
   logic [2:0]       dbg_state;

   dcache_flush_walker dut (
      .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_busy(flush_busy),
      .flush_done(flush_done), .arr_rindex(arr_rindex), .arr_windex(arr_windex),
      .valid_in(valid_in), .dirty_in(dirty_in), .tag_in(tag_in), .data_in(data_in),
      .dirty_load(dirty_load), .dirty_datain(dirty_datain), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
      .flush_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Array contents (the dcache state the walker flushes)
   logic            valid_m [NS][NW];
   logic            dirty_m [NS][NW];
   logic [ST-1:0]   tag_m   [NS][NW];
   logic [SL-1:0]   data_m  [NS][NW];

   // Registered-read arrays; a load forwards datain to the output on the next cycle.
   always @(posedge clk) begin
      for (int w = 0; w < NW; w++) begin
         valid_in[w]           <= valid_m[arr_rindex][w];
         tag_in[w*ST +: ST]    <= tag_m[arr_rindex][w];
         data_in[w*SL +: SL]   <= data_m[arr_rindex][w];
         dirty_in[w]           <= (dirty_load[w] && arr_windex == arr_rindex) ?
                                  dirty_datain : dirty_m[arr_rindex][w];
      end
      for (int w = 0; w < NW; w++)
         if (dirty_load[w]) dirty_m[arr_windex][w] = dirty_datain;
   end

   // Scoreboard and memory responder state
   logic [W-1:0]  exp_q[$];
   int            force_delay = -1;
   int            max_delay = 3;
   bit            spurious = 1'b0;
   int            delay_sum = 0;
   int            got_writes = 0;
   int            wb_cnt = 0, cur_delay = 0;
   bit            in_wb = 1'b0;
   bit            clr_pending = 1'b0;
   logic [2:0]    exp_clr_set = '0;
   logic [NW-1:0] exp_clr_load = '0;
   logic [31:0]   hold_addr = '0, last_addr = '0;
   logic [SL-1:0] hold_data = '0;
   logic [4:0]    last_clr = '0;

   // Memory: acknowledge each write after a chosen delay, check hold stability,
   // score the written line, then expect the matching dirty clear.
   always @(negedge clk) begin
      if (!rst_n) begin
         pmem_resp   = 1'b0;
         in_wb       = 1'b0;
         clr_pending = 1'b0;
      end else begin
         if (dirty_load != '0) begin
            assert (clr_pending) else begin
               n_err++;
               $error("FAIL clr_unexpected: observed load %0h expected none", dirty_load);
            end
            check("clr_load", dirty_load, exp_clr_load);
            check("clr_windex", arr_windex, exp_clr_set);
            check("clr_datain", dirty_datain, 1'b0);
            last_clr    = {arr_windex, dirty_load};
            clr_pending = 1'b0;
         end
         if (pmem_write) begin
            if (!in_wb) begin
               in_wb     = 1'b1;
               wb_cnt    = 0;
               cur_delay = (force_delay >= 0) ? force_delay : $urandom_range(0, max_delay);
               delay_sum += cur_delay;
               hold_addr = pmem_address;
               hold_data = pmem_wdata;
            end else begin
               check("wb_addr_stable", pmem_address, hold_addr);
               check("wb_data_stable", pmem_wdata, hold_data);
            end
            if (wb_cnt == cur_delay) begin
               pmem_resp = 1'b1;
               in_wb     = 1'b0;
               got_writes++;
               last_addr = pmem_address;
               assert (exp_q.size() > 0) else begin
                  n_err++;
                  $error("FAIL wr_extra: observed write %0h expected none", pmem_address);
               end
               if (exp_q.size() > 0) begin
                  logic [W-1:0] e;
                  e = exp_q.pop_front();
                  check("wr_addr", pmem_address, e[W-2 -: 32]);
                  check("wr_data", pmem_wdata, e[SL-1:0]);
                  exp_clr_set  = e[SL+7 -: 3];
                  exp_clr_load = NW'(1) << e[W-1];
                  clr_pending  = 1'b1;
               end
            end else begin
               pmem_resp = 1'b0;
               wb_cnt++;
            end
         end else begin
            in_wb     = 1'b0;
            pmem_resp = spurious && ($urandom_range(0, 2) == 0);
         end
      end
   end

   task automatic rand_line(output logic [SL-1:0] d);
      for (int i = 0; i < SL / 32; i++) d[i*32 +: 32] = $urandom;
   endtask

   task automatic fill_arrays(input int pv, input int pd);
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            valid_m[s][w] = ($urandom_range(0, 99) < pv);
            dirty_m[s][w] = ($urandom_range(0, 99) < pd);
            tag_m[s][w]   = ST'($urandom);
            rand_line(data_m[s][w]);
         end
   endtask

   // Full flush with the expected write list built from the array contents.
   task automatic run_flush(input bit pulses);
      int k;
      int n_exp;
      int left;
      logic [2:0] s3;
      exp_q.delete();
      n_exp = 0;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            if (valid_m[s][w] && dirty_m[s][w]) begin
               s3 = s[2:0];
               exp_q.push_back({w[0], tag_m[s][w], s3, 5'b0, data_m[s][w]});
               n_exp++;
            end
      delay_sum  = 0;
      got_writes = 0;
      @(negedge clk) flush_req = 1'b1;
      @(negedge clk) flush_req = 1'b0;
      k = 1;
      check("rindex_start", arr_rindex, 3'd0);
      while (flush_done !== 1'b1 && k < 3000) begin
         check("busy_walk", flush_busy, 1'b1);
         flush_req = pulses && (k == 3 || k == 8);
         @(negedge clk);
         k++;
      end
      flush_req = 1'b0;
      check("done_seen", flush_done, 1'b1);
      check("done_cycle", k, 2 * NS + 1 + 4 * n_exp + delay_sum);
      check("writes", got_writes, n_exp);
      check("exp_left", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("done_single", flush_done, 1'b0);
         check("idle_busy", flush_busy, 1'b0);
      end
      left = 0;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            if (valid_m[s][w] && dirty_m[s][w]) left++;
      check("dirty_left", left, 0);
   endtask

   initial begin
      int t;
      // Reset state
      fill_arrays(0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", flush_busy, 1'b0);
      check("rst_done", flush_done, 1'b0);
      check("rst_write", pmem_write, 1'b0);
      check("rst_load", dirty_load, '0);
      check("rst_rindex", arr_rindex, 3'd0);
      check("rst_addr", pmem_address, 32'd0);
      check("rst_wdata", pmem_wdata, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: nothing valid
      run_flush(1'b0);

      // 2: set 3 way 1 dirty
      fill_arrays(0, 0);
      valid_m[3][1] = 1'b1;
      dirty_m[3][1] = 1'b1;
      tag_m[3][1]   = 24'hABCDEF;
      run_flush(1'b0);
      check("t2_addr", last_addr, 32'hABCDEF60);
      check("t2_clear", last_clr, {3'd3, 2'b10});

      // 3: set 7 both ways dirty
      fill_arrays(0, 0);
      for (int w = 0; w < NW; w++) begin
         valid_m[7][w] = 1'b1;
         dirty_m[7][w] = 1'b1;
      end
      run_flush(1'b0);

      // 4: slow memory
      fill_arrays(40, 50);
      force_delay = 10;
      run_flush(1'b0);

      // 5: reset during write-back
      fill_arrays(0, 0);
      valid_m[2][0] = 1'b1;
      dirty_m[2][0] = 1'b1;
      valid_m[5][1] = 1'b1;
      dirty_m[5][1] = 1'b1;
      force_delay = 50;
      @(negedge clk) flush_req = 1'b1;
      @(negedge clk) flush_req = 1'b0;
      t = 0;
      while (pmem_write !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("t5_wb_reached", pmem_write, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_write_drop", pmem_write, 1'b0);
      check("t5_busy_drop", flush_busy, 1'b0);
      check("t5_rindex", arr_rindex, 3'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      force_delay = -1;
      @(negedge clk);
      run_flush(1'b0);

      // 6: clean lines, stray requests and stray acks while busy
      fill_arrays(100, 0);
      valid_m[4][0] = 1'b1;
      dirty_m[4][0] = 1'b1;
      spurious = 1'b1;
      run_flush(1'b1);

      // Randomized array contents
      for (int r = 0; r < 6; r++) begin
         fill_arrays($urandom_range(20, 100), $urandom_range(10, 90));
         max_delay = $urandom_range(0, 4);
         run_flush(r[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
